filter_mode_ctrl: RTL and testbench

Frame-synchronous mode controller for the camera filter chain. It turns raw DE1-SoC push-button presses, or an optional automatic demo cycle, into a selected filter mode. The selected mode drives a one-hot `en` vector that fans out to the filter stages: cartoon, blur, edge and the others. Mode changes are committed only at a frame boundary (end of VGA vertical sync), so a frame is never rendered with mixed filter settings.

---
 rtl/filter_mode_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_filter_mode_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : filter_mode_ctrl
// Purpose  : Debounced key / demo-driven filter mode selector that commits
//            mode changes only at VGA frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module filter_mode_ctrl #(
    parameter int NUM_MODES       = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEMO_FRAMES     = 120,
    parameter int MW              = $clog2(NUM_MODES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_next_n,
    input  logic                 key_prev_n,
    input  logic                 demo_sw,
    input  logic                 vs_n,
    output logic [MW-1:0]        mode,
    output logic [NUM_MODES-2:0] filter_en,
    output logic                 mode_changed,
    output logic                 pending
);

    localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_DF_W = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;

    // Step encoding: two's-complement style {0, +1, -1}
    localparam logic [1:0] c_STEP_0 = 2'b00;
    localparam logic [1:0] c_STEP_P = 2'b01;
    localparam logic [1:0] c_STEP_M = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    logic [3:0]            r_sync1;
    logic [3:0]            r_sync2;
    logic [1:0]            w_key_sync;
    logic [1:0]            w_press;
    logic                  w_demo_on;
    logic                  w_vs_sync;
    logic                  r_vs_prev;
    logic                  r_frame_start;
    logic [c_DF_W-1:0]     r_demo_cnt;
    logic                  w_demo_step;
    logic                  w_ev_next;
    logic                  w_ev_prev;
    logic                  w_key_ev;
    logic [1:0]            w_key_dir;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_step;
    logic [1:0]            w_step_nxt;
    logic [1:0]            r_defer;
    logic [1:0]            w_defer_nxt;
    logic                  w_apply;
    logic [MW-1:0]         r_mode;
    logic [MW-1:0]         w_mode_nxt;
    logic [NUM_MODES-2:0]  r_filter_en;
    logic [NUM_MODES-2:0]  w_en_nxt;
    logic                  r_mode_changed;

    // Bit order: {vs_n, demo_sw, key_prev_n, key_next_n}
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {vs_n, demo_sw, key_prev_n, key_next_n};
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_sync = r_sync2[1:0];
    assign w_demo_on  = r_sync2[2];
    assign w_vs_sync  = r_sync2[3];

    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic [c_DB_W-1:0] r_cnt;
        logic              r_acc;
        logic              r_press;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt   <= '0;
                r_acc   <= 1'b1;
                r_press <= 1'b0;
            end else begin
                r_press <= 1'b0;
                if (w_key_sync[gi] != r_acc) begin
                    if (r_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_acc   <= w_key_sync[gi];
                        r_press <= r_acc;  // only the 1->0 flip is a press
                    end else begin
                        r_cnt <= r_cnt + c_DB_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev     <= 1'b1;
            r_frame_start <= 1'b0;
            r_demo_cnt    <= '0;
        end else begin
            r_vs_prev     <= w_vs_sync;
            r_frame_start <= w_vs_sync & ~r_vs_prev;
            if (!w_demo_on) begin
                r_demo_cnt <= '0;
            end else if (r_frame_start) begin
                if (r_demo_cnt == c_DF_W'(DEMO_FRAMES - 1))
                    r_demo_cnt <= '0;
                else
                    r_demo_cnt <= r_demo_cnt + c_DF_W'(1);
            end
        end
    end

    assign w_demo_step = w_demo_on & r_frame_start &
                         (r_demo_cnt == c_DF_W'(DEMO_FRAMES - 1));
    assign w_ev_next   = w_press[0] & ~w_press[1];
    assign w_ev_prev   = w_press[1] & ~w_press[0];
    assign w_key_ev    = w_ev_next | w_ev_prev;
    assign w_key_dir   = w_ev_next ? c_STEP_P : c_STEP_M;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_step         <= c_STEP_0;
            r_defer        <= c_STEP_0;
            r_mode         <= '0;
            r_filter_en    <= '0;
            r_mode_changed <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_step         <= w_step_nxt;
            r_defer        <= w_defer_nxt;
            r_mode         <= w_mode_nxt;
            r_filter_en    <= w_en_nxt;
            r_mode_changed <= w_apply;
        end
    end

    // A key event coinciding with the commit boundary is parked in r_defer
    // and re-evaluated in APPLY against the then-cleared step.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_defer_nxt = c_STEP_0;
        w_apply     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_key_ev) begin
                    w_step_nxt  = w_key_dir;
                    w_state_nxt = S_ARMED;
                end else if (w_demo_step) begin
                    w_step_nxt  = c_STEP_P;
                    w_state_nxt = S_APPLY;
                end
            end
            S_ARMED: begin
                if (r_frame_start) begin
                    w_state_nxt = S_APPLY;
                    if (w_key_ev)
                        w_defer_nxt = w_key_dir;
                end else if (w_key_ev && (w_key_dir != r_step)) begin
                    w_step_nxt  = c_STEP_0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_APPLY: begin
                w_apply = 1'b1;
                if (w_key_ev) begin
                    w_step_nxt  = w_key_dir;
                    w_state_nxt = S_ARMED;
                end else if (r_defer != c_STEP_0) begin
                    w_step_nxt  = r_defer;
                    w_state_nxt = S_ARMED;
                end else begin
                    w_step_nxt  = c_STEP_0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_step_nxt  = c_STEP_0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (w_apply) begin
            if (r_step == c_STEP_P)
                w_mode_nxt = (r_mode == MW'(NUM_MODES - 1)) ? '0 : r_mode + MW'(1);
            else if (r_step == c_STEP_M)
                w_mode_nxt = (r_mode == '0) ? MW'(NUM_MODES - 1) : r_mode - MW'(1);
        end
    end

    always_comb begin
        w_en_nxt = '0;
        for (int k = 1; k < NUM_MODES; k++) begin
            if (w_mode_nxt == MW'(k))
                w_en_nxt[k-1] = 1'b1;
        end
    end

    assign mode         = r_mode;
    assign filter_en    = r_filter_en;
    assign mode_changed = r_mode_changed;
    assign pending      = (r_state == S_ARMED);

endmodule
`default_nettype wire

// File: tb/tb_filter_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_mode_ctrl
// Purpose  : Self-checking scoreboard bench for filter_mode_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_next_n = 1'b1;
    logic       key_prev_n = 1'b1;
    logic       demo_sw = 1'b0;
    logic       vs_n = 1'b1;
    logic [2:0] mode;
    logic [6:0] filter_en;
    logic       mode_changed;
    logic       pending;

    int n_checks = 0;
    int n_fail   = 0;
    int sb_q[$];
    int sb_e;
    int em;
    bit prev_mc = 1'b0;

    always #5 clk = ~clk;

    filter_mode_ctrl #(
        .NUM_MODES       (8),
        .DEBOUNCE_CYCLES (4),
        .DEMO_FRAMES     (3)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .key_next_n   (key_next_n),
        .key_prev_n   (key_prev_n),
        .demo_sw      (demo_sw),
        .vs_n         (vs_n),
        .mode         (mode),
        .filter_en    (filter_en),
        .mode_changed (mode_changed),
        .pending      (pending)
    );

    function automatic int exp_en(input int m);
        return (m == 0) ? 0 : (1 << (m - 1));
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Every commit pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && mode_changed) begin
            check_val("mc_width", int'(prev_mc), 0);
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_commit", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check_val("sb_mode", int'(mode), sb_e);
                check_val("sb_en", int'(filter_en), exp_en(sb_e));
            end
        end
        prev_mc = mode_changed;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit is_next);
        if (is_next) key_next_n = 1'b0;
        else         key_prev_n = 1'b0;
        cyc(10);
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        cyc(10);
    endtask

    // Raw vs_n rise -> mode_changed is 5 negedges later (frame_start at +3)
    task automatic frame(input bit expect_commit, input int exp_m);
        int lat;
        lat = -1;
        if (expect_commit) sb_q.push_back(exp_m);
        vs_n = 1'b0;
        cyc(4);
        vs_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mode_changed && lat < 0) lat = i;
        end
        if (expect_commit) check_val("commit_latency", lat, 5);
        else               check_val("no_commit", lat, -1);
        @(posedge clk);
        #1;
    endtask

    // Next key pressed so that its debounced event lands in the APPLY cycle
    task automatic apply_frame(input int exp_m);
        int lat;
        lat = -1;
        sb_q.push_back(exp_m);
        vs_n = 1'b0;
        cyc(2);
        key_next_n = 1'b0;
        cyc(2);
        vs_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mode_changed && lat < 0) lat = i;
        end
        check_val("apply_latency", lat, 5);
        @(posedge clk);
        #1;
        key_next_n = 1'b1;
        cyc(10);
    endtask

    initial begin
        rst = 1'b1;
        cyc(3);
        @(negedge clk);
        check_val("rst_mode", int'(mode), 0);
        check_val("rst_en", int'(filter_en), 0);
        check_val("rst_mc", int'(mode_changed), 0);
        check_val("rst_pending", int'(pending), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(2);

        for (int i = 0; i < 5; i++) begin
            key_next_n = 1'b0;
            cyc(3);
            key_next_n = 1'b1;
            cyc(3);
        end
        cyc(8);
        check_val("bounce_pending", int'(pending), 0);
        frame(1'b0, 0);
        check_val("bounce_mode", int'(mode), 0);

        key_next_n = 1'b0;
        cyc(10);
        check_val("press_pending", int'(pending), 1);
        key_next_n = 1'b1;
        cyc(10);
        check_val("release_pending", int'(pending), 1);
        frame(1'b1, 1);
        check_val("commit_pending", int'(pending), 0);
        check_val("commit_mode", int'(mode), 1);
        check_val("commit_en", int'(filter_en), 1);

        press(1'b0);
        frame(1'b1, 0);
        press(1'b0);
        frame(1'b1, 7);
        check_val("wrap_mode", int'(mode), 7);
        check_val("wrap_en", int'(filter_en), 64);

        press(1'b1);
        check_val("cancel_armed", int'(pending), 1);
        press(1'b0);
        check_val("cancel_pending", int'(pending), 0);
        frame(1'b0, 0);
        check_val("cancel_mode", int'(mode), 7);

        press(1'b1);
        apply_frame(0);
        check_val("apply_rearm", int'(pending), 1);
        frame(1'b1, 1);
        check_val("apply_second", int'(mode), 1);

        demo_sw = 1'b1;
        cyc(4);
        em = 1;
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 2) begin
                em = (em + 1) % 8;
                frame(1'b1, em);
            end else begin
                frame(1'b0, 0);
            end
        end
        check_val("demo_mode", int'(mode), 4);
        frame(1'b0, 0);
        frame(1'b0, 0);
        press(1'b0);
        frame(1'b1, 3);
        demo_sw = 1'b0;
        cyc(4);
        check_val("demo_prev_mode", int'(mode), 3);

        press(1'b1);
        check_val("rstmid_armed", int'(pending), 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_val("rstmid_mode", int'(mode), 0);
        check_val("rstmid_en", int'(filter_en), 0);
        check_val("rstmid_pending", int'(pending), 0);
        frame(1'b0, 0);
        check_val("rstmid_after", int'(mode), 0);

        cyc(4);
        check_val("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
